// File: rtl/multicycle_control_unit.sv
// Multi-cycle control sequencer: walks each instruction through FETCH/DECODE/EXEC/MEM/WB
// and drives one state's worth of datapath strobes, with memory-wait timeout and illegal-opcode trap.
module multicycle_control_unit #(
    parameter int OPCODE_W       = 3,
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CNT_W          = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                instr_valid,
    input  logic                mem_ready,
    input  logic                zero,
    output logic                pc_write,
    output logic                ir_write,
    output logic                reg_dst,
    output logic                jump,
    output logic                branch,
    output logic                mem_read,
    output logic                mem_write,
    output logic                mem_to_reg,
    output logic                alu_src,
    output logic                reg_write,
    output logic [1:0]          alu_op,
    output logic                busy,
    output logic                illegal,
    output logic                timeout,
    output logic                instr_retired,
    output logic [CNT_W-1:0]    retire_count
);
    localparam int                WAIT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_LW   = 3'd1;
    localparam logic [2:0] OP_SW   = 3'd2;
    localparam logic [2:0] OP_J    = 3'd3;
    localparam logic [2:0] OP_ADD  = 3'd4;
    localparam logic [2:0] OP_ADDI = 3'd5;
    localparam logic [2:0] OP_SUB  = 3'd6;
    localparam logic [2:0] OP_BEQ  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    state_t             r_state;
    state_t             w_next;
    // Only the low three bits are kept: any opcode with upper bits set traps in DECODE.
    logic [2:0]         r_op_q;
    logic [WAIT_W-1:0]  r_wait;
    logic               r_illegal;
    logic               r_timeout;
    logic [CNT_W-1:0]   r_retire_count;
    logic               w_retire;
    logic               w_waiting;
    logic               w_expired;
    logic               w_set_illegal;
    logic               w_set_timeout;
    logic               w_op_illegal;

    assign w_op_illegal  = |(opcode >> 3);
    assign w_waiting     = ((r_state == S_FETCH) || (r_state == S_MEM)) && !mem_ready;
    assign w_expired     = w_waiting && (r_wait == WAIT_LAST);
    assign busy          = (r_state != S_IDLE) && (r_state != S_TRAP);
    assign illegal       = r_illegal;
    assign timeout       = r_timeout;
    assign retire_count  = r_retire_count;
    assign instr_retired = w_retire;

    always_comb begin
        w_next        = r_state;
        w_retire      = 1'b0;
        w_set_illegal = 1'b0;
        w_set_timeout = 1'b0;
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        jump          = 1'b0;
        branch        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src       = 1'b0;
        reg_write     = 1'b0;
        alu_op        = 2'b00;
        case (r_state)
            S_IDLE: begin
                if (instr_valid) w_next = S_FETCH;
            end
            S_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    w_next   = S_DECODE;
                end else if (w_expired) begin
                    w_next        = S_TRAP;
                    w_set_timeout = 1'b1;
                end
            end
            S_DECODE: begin
                if (w_op_illegal) begin
                    w_next        = S_TRAP;
                    w_set_illegal = 1'b1;
                end else if (opcode[2:0] == OP_NOP) begin
                    w_retire = 1'b1;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                case (r_op_q)
                    OP_ADD, OP_SUB: begin
                        reg_dst = 1'b1;
                        alu_op  = 2'b10;
                        w_next  = S_WB;
                    end
                    OP_ADDI: begin
                        alu_src = 1'b1;
                        alu_op  = 2'b10;
                        w_next  = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_src = 1'b1;
                        w_next  = S_MEM;
                    end
                    OP_J: begin
                        jump     = 1'b1;
                        pc_write = 1'b1;
                        w_retire = 1'b1;
                    end
                    OP_BEQ: begin
                        branch   = 1'b1;
                        alu_op   = 2'b01;
                        pc_write = zero;
                        w_retire = 1'b1;
                    end
                    default: w_retire = 1'b1;
                endcase
            end
            S_MEM: begin
                mem_read  = (r_op_q == OP_LW);
                mem_write = (r_op_q != OP_LW);
                if (mem_ready) begin
                    if (r_op_q == OP_LW) w_next   = S_WB;
                    else                 w_retire = 1'b1;
                end else if (w_expired) begin
                    w_next        = S_TRAP;
                    w_set_timeout = 1'b1;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                reg_dst    = (r_op_q == OP_ADD) || (r_op_q == OP_SUB);
                mem_to_reg = (r_op_q == OP_LW);
                w_retire   = 1'b1;
            end
            default: w_next = S_TRAP;
        endcase
        if (w_retire) w_next = instr_valid ? S_FETCH : S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_op_q         <= 3'd0;
            r_wait         <= '0;
            r_illegal      <= 1'b0;
            r_timeout      <= 1'b0;
            r_retire_count <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) r_op_q <= opcode[2:0];
            // Any fresh entry into FETCH or MEM starts its wait budget from zero.
            if (w_waiting)              r_wait <= r_wait + 1'b1;
            else if (w_next != r_state) r_wait <= '0;
            if (w_set_illegal) r_illegal <= 1'b1;
            if (w_set_timeout) r_timeout <= 1'b1;
            if (w_retire)      r_retire_count <= r_retire_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-cycle strobe vectors against hand-built tables.
module tb_multicycle_control_unit;
    logic       clk;
    logic       rst;
    logic [3:0] opcode;
    logic       instr_valid, mem_ready, zero;
    logic       pc_write, ir_write, reg_dst, jump, branch, mem_read, mem_write;
    logic       mem_to_reg, alu_src, reg_write, busy, illegal, timeout, instr_retired;
    logic [1:0] alu_op;
    logic [15:0] retire_count;
    int vec, errs;

    multicycle_control_unit #(.OPCODE_W(4), .TIMEOUT_CYCLES(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .instr_valid(instr_valid),
        .mem_ready(mem_ready), .zero(zero), .pc_write(pc_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .jump(jump), .branch(branch), .mem_read(mem_read),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg), .alu_src(alu_src),
        .reg_write(reg_write), .alu_op(alu_op), .busy(busy), .illegal(illegal),
        .timeout(timeout), .instr_retired(instr_retired), .retire_count(retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_write, ir_write, reg_dst, jump, branch, mem_read, mem_write, mem_to_reg, alu_src, reg_write, alu_op, busy, instr_retired}
    localparam logic [13:0] E_IDLE  = 14'b00000000000000;
    localparam logic [13:0] E_FR    = 14'b11000100000010;
    localparam logic [13:0] E_FW    = 14'b00000100000010;
    localparam logic [13:0] E_DEC   = 14'b00000000000010;
    localparam logic [13:0] E_NOP   = 14'b00000000000011;
    localparam logic [13:0] E_XADD  = 14'b00100000001010;
    localparam logic [13:0] E_XADDI = 14'b00000000101010;
    localparam logic [13:0] E_XLS   = 14'b00000000100010;
    localparam logic [13:0] E_XJ    = 14'b10010000000011;
    localparam logic [13:0] E_XB1   = 14'b10001000000111;
    localparam logic [13:0] E_XB0   = 14'b00001000000111;
    localparam logic [13:0] E_MLW   = 14'b00000100000010;
    localparam logic [13:0] E_MSW   = 14'b00000010000010;
    localparam logic [13:0] E_MSWR  = 14'b00000010000011;
    localparam logic [13:0] E_WADD  = 14'b00100000010011;
    localparam logic [13:0] E_WLW   = 14'b00000001010011;
    localparam logic [13:0] E_WADDI = 14'b00000000010011;

    localparam logic [3:0] NOP = 4'd0, LW = 4'd1, SW = 4'd2, J = 4'd3;
    localparam logic [3:0] ADD = 4'd4, ADDI = 4'd5, BEQ = 4'd7, BAD = 4'b1100;

    typedef struct packed {
        logic [3:0]  op;
        logic        v;
        logic        r;
        logic        z;
        logic [13:0] e;
    } cyc_t;

    function automatic logic [13:0] obs();
        return {pc_write, ir_write, reg_dst, jump, branch, mem_read, mem_write,
                mem_to_reg, alu_src, reg_write, alu_op, busy, instr_retired};
    endfunction

    task automatic do_reset();
        rst = 1'b1; instr_valid = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = 4'd0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; instr_valid = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = 4'd0;
        #2 rst = 1'b1;
        #1;
        vec++;
        if ({obs(), illegal, timeout, retire_count} !== 32'd0) begin
            errs++; $display("FAIL reset_async: got %b/%b/%b/%0d want all 0", obs(), illegal, timeout, retire_count);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        vec++;
        if (obs() !== E_IDLE) begin errs++; $display("FAIL reset_idle: got %b want %b", obs(), E_IDLE); end
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        cyc_t t [6];
        t = '{'{ADD,1'b1,1'b1,1'b0,E_IDLE}, '{ADD,1'b0,1'b1,1'b0,E_FR}, '{ADD,1'b0,1'b1,1'b0,E_DEC},
              '{ADD,1'b0,1'b1,1'b0,E_XADD}, '{ADD,1'b0,1'b1,1'b0,E_WADD}, '{ADD,1'b0,1'b1,1'b0,E_IDLE}};
        foreach (t[i]) begin
            opcode = t[i].op; instr_valid = t[i].v; mem_ready = t[i].r; zero = t[i].z;
            @(negedge clk); vec++;
            if (obs() !== t[i].e) begin errs++; $display("FAIL add cyc%0d: got %b want %b", i, obs(), t[i].e); end
            @(posedge clk); #1;
        end
        vec++;
        if (retire_count !== 16'd1) begin errs++; $display("FAIL add_count: got %0d want 1", retire_count); end
    endtask

    task automatic test_lw_wait();
        cyc_t t [10];
        t = '{'{LW,1'b1,1'b1,1'b0,E_IDLE}, '{LW,1'b0,1'b1,1'b0,E_FR}, '{LW,1'b0,1'b1,1'b0,E_DEC},
              '{LW,1'b0,1'b0,1'b0,E_XLS},  '{LW,1'b0,1'b0,1'b0,E_MLW}, '{LW,1'b0,1'b0,1'b0,E_MLW},
              '{LW,1'b0,1'b0,1'b0,E_MLW},  '{LW,1'b0,1'b1,1'b0,E_MLW}, '{LW,1'b0,1'b1,1'b0,E_WLW},
              '{LW,1'b0,1'b1,1'b0,E_IDLE}};
        foreach (t[i]) begin
            opcode = t[i].op; instr_valid = t[i].v; mem_ready = t[i].r; zero = t[i].z;
            @(negedge clk); vec++;
            if (obs() !== t[i].e) begin errs++; $display("FAIL lw_wait cyc%0d: got %b want %b", i, obs(), t[i].e); end
            @(posedge clk); #1;
        end
        vec++;
        if (retire_count !== 16'd2) begin errs++; $display("FAIL lw_count: got %0d want 2", retire_count); end
    endtask

    task automatic test_beq();
        cyc_t t [10];
        t = '{'{BEQ,1'b1,1'b1,1'b1,E_IDLE}, '{BEQ,1'b0,1'b1,1'b1,E_FR}, '{BEQ,1'b0,1'b1,1'b1,E_DEC},
              '{BEQ,1'b0,1'b1,1'b1,E_XB1},  '{BEQ,1'b0,1'b1,1'b1,E_IDLE},
              '{BEQ,1'b1,1'b1,1'b0,E_IDLE}, '{BEQ,1'b0,1'b1,1'b0,E_FR}, '{BEQ,1'b0,1'b1,1'b0,E_DEC},
              '{BEQ,1'b0,1'b1,1'b0,E_XB0},  '{BEQ,1'b0,1'b1,1'b0,E_IDLE}};
        foreach (t[i]) begin
            opcode = t[i].op; instr_valid = t[i].v; mem_ready = t[i].r; zero = t[i].z;
            @(negedge clk); vec++;
            if (obs() !== t[i].e) begin errs++; $display("FAIL beq cyc%0d: got %b want %b", i, obs(), t[i].e); end
            @(posedge clk); #1;
        end
        vec++;
        if (retire_count !== 16'd4) begin errs++; $display("FAIL beq_count: got %0d want 4", retire_count); end
    endtask

    // NOP fetch waits three cycles and gets mem_ready on the last allowed cycle.
    task automatic test_nop_jump();
        cyc_t t [12];
        t = '{'{NOP,1'b1,1'b0,1'b0,E_IDLE}, '{NOP,1'b0,1'b0,1'b0,E_FW}, '{NOP,1'b0,1'b0,1'b0,E_FW},
              '{NOP,1'b0,1'b0,1'b0,E_FW},   '{NOP,1'b0,1'b1,1'b0,E_FR}, '{NOP,1'b0,1'b1,1'b0,E_NOP},
              '{NOP,1'b0,1'b1,1'b0,E_IDLE},
              '{J,1'b1,1'b1,1'b0,E_IDLE},   '{J,1'b0,1'b1,1'b0,E_FR},   '{J,1'b0,1'b1,1'b0,E_DEC},
              '{J,1'b0,1'b1,1'b0,E_XJ},     '{J,1'b0,1'b1,1'b0,E_IDLE}};
        foreach (t[i]) begin
            opcode = t[i].op; instr_valid = t[i].v; mem_ready = t[i].r; zero = t[i].z;
            @(negedge clk); vec++;
            if (obs() !== t[i].e) begin errs++; $display("FAIL nop_jump cyc%0d: got %b want %b", i, obs(), t[i].e); end
            @(posedge clk); #1;
        end
        vec++;
        if (retire_count !== 16'd6) begin errs++; $display("FAIL nop_jump_count: got %0d want 6", retire_count); end
    endtask

    task automatic test_back_to_back();
        cyc_t t [10];
        t = '{'{ADDI,1'b1,1'b1,1'b0,E_IDLE}, '{ADDI,1'b0,1'b1,1'b0,E_FR}, '{ADDI,1'b0,1'b1,1'b0,E_DEC},
              '{ADDI,1'b0,1'b1,1'b0,E_XADDI}, '{ADDI,1'b1,1'b1,1'b0,E_WADDI},
              '{SW,1'b0,1'b1,1'b0,E_FR},      '{SW,1'b0,1'b1,1'b0,E_DEC},   '{SW,1'b0,1'b1,1'b0,E_XLS},
              '{SW,1'b0,1'b1,1'b0,E_MSWR},    '{SW,1'b0,1'b1,1'b0,E_IDLE}};
        foreach (t[i]) begin
            opcode = t[i].op; instr_valid = t[i].v; mem_ready = t[i].r; zero = t[i].z;
            @(negedge clk); vec++;
            if (obs() !== t[i].e) begin errs++; $display("FAIL b2b cyc%0d: got %b want %b", i, obs(), t[i].e); end
            @(posedge clk); #1;
        end
        vec++;
        if (retire_count !== 16'd8) begin errs++; $display("FAIL b2b_count: got %0d want 8", retire_count); end
    endtask

    task automatic test_timeout();
        cyc_t t [11];
        t = '{'{SW,1'b1,1'b1,1'b0,E_IDLE}, '{SW,1'b0,1'b1,1'b0,E_FR},  '{SW,1'b0,1'b1,1'b0,E_DEC},
              '{SW,1'b0,1'b0,1'b0,E_XLS},  '{SW,1'b0,1'b0,1'b0,E_MSW}, '{SW,1'b0,1'b0,1'b0,E_MSW},
              '{SW,1'b0,1'b0,1'b0,E_MSW},  '{SW,1'b0,1'b0,1'b0,E_MSW}, '{SW,1'b1,1'b1,1'b0,E_IDLE},
              '{SW,1'b1,1'b1,1'b0,E_IDLE}, '{SW,1'b1,1'b1,1'b0,E_IDLE}};
        foreach (t[i]) begin
            opcode = t[i].op; instr_valid = t[i].v; mem_ready = t[i].r; zero = t[i].z;
            @(negedge clk); vec++;
            if (obs() !== t[i].e) begin errs++; $display("FAIL timeout cyc%0d: got %b want %b", i, obs(), t[i].e); end
            @(posedge clk); #1;
        end
        vec++;
        if ({timeout, illegal, retire_count} !== {1'b1, 1'b0, 16'd8}) begin
            errs++; $display("FAIL timeout_flags: got to=%b il=%b cnt=%0d want to=1 il=0 cnt=8", timeout, illegal, retire_count);
        end
        do_reset();
        vec++;
        if ({obs(), timeout, retire_count} !== 31'd0) begin
            errs++; $display("FAIL timeout_release: got %b to=%b cnt=%0d want 0", obs(), timeout, retire_count);
        end
    endtask

    task automatic test_illegal();
        cyc_t t [5];
        t = '{'{BAD,1'b1,1'b1,1'b0,E_IDLE}, '{BAD,1'b0,1'b1,1'b0,E_FR}, '{BAD,1'b0,1'b1,1'b0,E_DEC},
              '{BAD,1'b1,1'b1,1'b0,E_IDLE}, '{BAD,1'b1,1'b1,1'b0,E_IDLE}};
        foreach (t[i]) begin
            opcode = t[i].op; instr_valid = t[i].v; mem_ready = t[i].r; zero = t[i].z;
            @(negedge clk); vec++;
            if (obs() !== t[i].e) begin errs++; $display("FAIL illegal cyc%0d: got %b want %b", i, obs(), t[i].e); end
            @(posedge clk); #1;
        end
        vec++;
        if ({illegal, timeout, retire_count} !== {1'b1, 1'b0, 16'd0}) begin
            errs++; $display("FAIL illegal_flags: got il=%b to=%b cnt=%0d want il=1 to=0 cnt=0", illegal, timeout, retire_count);
        end
        do_reset();
    endtask

    task automatic test_reset_mid();
        cyc_t t [3];
        t = '{'{ADDI,1'b1,1'b1,1'b0,E_IDLE}, '{ADDI,1'b0,1'b1,1'b0,E_FR}, '{ADDI,1'b0,1'b1,1'b0,E_DEC}};
        foreach (t[i]) begin
            opcode = t[i].op; instr_valid = t[i].v; mem_ready = t[i].r; zero = t[i].z;
            @(negedge clk); vec++;
            if (obs() !== t[i].e) begin errs++; $display("FAIL rst_mid cyc%0d: got %b want %b", i, obs(), t[i].e); end
            @(posedge clk); #1;
        end
        @(negedge clk); vec++;
        if (obs() !== E_XADDI) begin errs++; $display("FAIL rst_mid_exec: got %b want %b", obs(), E_XADDI); end
        #1 rst = 1'b1;
        #1; vec++;
        if ({obs(), retire_count} !== 30'd0) begin
            errs++; $display("FAIL rst_mid_async: got %b cnt=%0d want 0", obs(), retire_count);
        end
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); vec++;
            if ({obs(), retire_count} !== 30'd0) begin
                errs++; $display("FAIL rst_mid_after%0d: got %b cnt=%0d want 0", i, obs(), retire_count);
            end
        end
    endtask

    initial begin
        vec = 0;
        errs = 0;
        test_reset();
        test_add();
        test_lw_wait();
        test_beq();
        test_nop_jump();
        test_back_to_back();
        test_timeout();
        test_illegal();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
